// File: rtl/wind_gen.sv
// Wind generator for the artillery game: random wind target per turn,
// frame-paced ramp of the displayed wind force toward that target.
module wind_gen #(
  parameter int          WIND_RESET = 64,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          RAMP_DIV   = 2,
  parameter int          STEP       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       new_turn,
  output logic [6:0] wind_force,
  output logic [6:0] wind_target,
  output logic       settled
);

  // An all-zero seed would lock the LFSR, so it is quietly replaced.
  localparam logic [15:0] SEED       = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [6:0]  FORCE_INIT = 7'(WIND_RESET);
  localparam logic [3:0]  DIV_LAST   = 4'(RAMP_DIV - 1);
  localparam logic [7:0]  STEP_W     = 8'(STEP);

  typedef enum logic {HOLD, RAMP} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic        vsync_q;
  logic        frame_tick;
  logic [3:0]  div_cnt;
  logic        step_en;
  logic [7:0]  force_w;
  logic [7:0]  target_w;
  logic [7:0]  up_gap;
  logic [7:0]  down_gap;
  logic [6:0]  next_force;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {lfsr[14:0], lfsr_fb};
  end

  always_ff @(posedge clk) begin
    if (rst) vsync_q <= 1'b0;
    else     vsync_q <= vsync;
  end

  assign frame_tick = vsync & ~vsync_q;
  assign step_en    = frame_tick && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst)
      div_cnt <= 4'd0;
    else if (new_turn)
      div_cnt <= 4'd0;
    else if (frame_tick)
      div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
  end

  // Gaps are taken in 8 bits so a full STEP never wraps past 0 or 127.
  assign force_w  = {1'b0, wind_force};
  assign target_w = {1'b0, wind_target};
  assign up_gap   = target_w - force_w;
  assign down_gap = force_w - target_w;

  always_comb begin
    next_force = wind_force;
    if (target_w > force_w) begin
      if (up_gap <= STEP_W) next_force = wind_target;
      else                  next_force = 7'(force_w + STEP_W);
    end else begin
      if (down_gap <= STEP_W) next_force = wind_target;
      else                    next_force = 7'(force_w - STEP_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HOLD;
      wind_force  <= FORCE_INIT;
      wind_target <= FORCE_INIT;
      settled     <= 1'b1;
    end else if (new_turn) begin
      state       <= RAMP;
      wind_target <= lfsr[6:0];
      settled     <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          settled <= 1'b1;
        end
        RAMP: begin
          if (wind_force == wind_target) begin
            state   <= HOLD;
            settled <= 1'b1;
          end else if (step_en) begin
            wind_force <= next_force;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: doc/wind_gen.md
WIND_GEN -- requirements
Module: wind_gen

Interface
REQ-001 Parameter WIND_RESET, 64, wind_force and wind_target value after reset (neutral bar position).
REQ-002 Parameter LFSR_SEED, 16'hACE1, LFSR load value at reset; a zero seed SHALL be replaced by 16'h0001.
REQ-003 Parameter RAMP_DIV, 2, number of vsync rising edges between ramp steps (legal range 1..15).
REQ-004 Parameter STEP, 1, maximum wind_force change per ramp step (legal range 1..127).
REQ-005 clk  input  1  system pixel clock; all state SHALL change on its rising edge only.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 vsync  input  1  vertical sync level from the VGA timing chain; frame-rate pacing source.
REQ-008 new_turn  input  1  single-cycle pulse requesting a new random wind for the next shot.
REQ-009 wind_force  output  7  current wind value driven to the wind bar drawing stage; 0..127.
REQ-010 wind_target  output  7  value wind_force is ramping toward.
REQ-011 settled  output  1  high when wind_force equals wind_target and the FSM is in HOLD.

Function
REQ-012 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clk cycle, independent of the FSM, and SHALL never reach zero.
REQ-013 A registered copy of vsync SHALL be kept; frame_tick SHALL be asserted for exactly one cycle when vsync is 1 and the registered copy is 0.
REQ-014 A frame divider counter SHALL count frame_tick events from 0 to RAMP_DIV-1; step_en SHALL pulse on the frame_tick that wraps it to 0.
REQ-015 The FSM SHALL have states HOLD and RAMP; reset state is HOLD.
REQ-016 In any state, new_turn=1 SHALL load wind_target <= LFSR[6:0] (value present that cycle), clear the frame divider, and enter RAMP on the next cycle.
REQ-017 In RAMP, on step_en with no new_turn: if |target - force| <= STEP, wind_force <= wind_target; otherwise wind_force moves STEP toward wind_target.
REQ-018 Arithmetic SHALL be done in 8-bit unsigned or wider; wind_force SHALL never leave 0..127 and never overshoot wind_target.
REQ-019 In RAMP, when wind_force equals wind_target at a cycle boundary, the FSM SHALL enter HOLD on the next cycle; settled SHALL be registered and rise in the same cycle as the HOLD entry.
REQ-020 If new_turn loads a target equal to the current wind_force, the FSM SHALL pass through RAMP for one cycle, then return to HOLD with no change to wind_force.
REQ-021 new_turn and step_en in the same cycle: new_turn wins; no step occurs that cycle.
REQ-022 new_turn during RAMP SHALL retarget from the current wind_force with no jump; settled stays 0.
REQ-023 In HOLD, wind_force and wind_target SHALL be stable regardless of vsync activity.
REQ-024 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-025 On rst=1: wind_force=WIND_RESET, wind_target=WIND_RESET, settled=1, FSM=HOLD, frame divider=0, registered vsync=0, LFSR=LFSR_SEED (or 1 if zero).
REQ-026 rst asserted mid-RAMP SHALL abort the ramp; outputs SHALL take reset values on the next edge.
REQ-027 rst has priority over new_turn and frame_tick in the same cycle.

Verification
REQ-028 Reset: hold rst 3 cycles -> wind_force=64, wind_target=64, settled=1; LFSR state equals 16'hACE1 on the first cycle after release.
REQ-029 Ramp up: with force 64, force target 70 (new_turn when LFSR[6:0]=70), RAMP_DIV=2, STEP=1 -> force increments by 1 every 2nd vsync rising edge, reaches 70 after 12 edges, settled rises the next cycle.
REQ-030 Clamp: with STEP=4, force 10, target 12 -> single step lands exactly on 12; no value 14 ever appears.
REQ-031 Retarget: new_turn mid-ramp (force 66, old target 90, new target 40) -> force decreases from 66 without a jump, settled stays 0 until 40.
REQ-032 Collision: new_turn and step_en in the same cycle -> wind_force unchanged that cycle, wind_target updated, divider restarts.
REQ-033 LFSR: run 65535 cycles from reset -> state returns to seed, zero never observed; vsync held high -> no frame_tick after the first edge.
